// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-add step per clock, LSB first.
// Sum, carry and signed overflow are registered and flagged by a done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_ovf;

  logic             w_h1_s;
  logic             w_h1_c;
  logic             w_s;
  logic             w_h2_c;
  logic             w_cnext;
  logic             w_last;
  logic [WIDTH-1:0] w_res_nx;

  // Full adder as two cascaded half-add steps.
  assign w_h1_s  = r_opa[0] ^ r_opb[0];
  assign w_h1_c  = r_opa[0] & r_opb[0];
  assign w_s     = w_h1_s ^ r_c;
  assign w_h2_c  = w_h1_s & r_c;
  assign w_cnext = w_h1_c | w_h2_c;

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_res_nx = (r_res >> 1) |
                    (WIDTH'(w_s) << (WIDTH - 1));

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_state_nx = S_ADD;
      S_ADD:  if (w_last) w_state_nx = S_DONE;
      S_DONE: w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa <= A;
            r_opb <= sub ? ~B : B;
            r_c   <= sub ? 1'b1 : cin;
            r_cnt <= '0;
            r_res <= '0;
          end
        end
        S_ADD: begin
          r_res <= w_res_nx;
          r_opa <= r_opa >> 1;
          r_opb <= r_opb >> 1;
          r_c   <= w_cnext;
          r_cnt <= r_cnt + 1'b1;
          // r_c here is still the carry into the MSB.
          if (w_last) begin
            r_sum   <= w_res_nx;
            r_carry <= w_cnext;
            r_ovf   <= r_c ^ w_cnext;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == S_ADD);
  assign done     = (r_state == S_DONE);
  assign sum      = r_sum;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Results are checked against an arithmetic reference model.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, sub, cin;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] sum;
  logic       carry, ovf;

  logic       s1_start, s1_sub, s1_cin;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       carry1, ovf1;

  int n_chk = 0;
  int n_fail = 0;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .sub(sub), .cin(cin), .A(a), .B(b),
    .busy(busy), .done(done), .sum(sum),
    .carry(carry), .overflow(ovf)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start),
    .sub(s1_sub), .cin(s1_cin), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .sum(sum1),
    .carry(carry1), .overflow(ovf1)
  );

  function automatic void model(
    input int w, input int ua, input int ub,
    input bit s, input bit ci,
    output int es, output bit ec, output bit eo);
    longint m, half, sa, sb, r, full;
    m    = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (s) begin
      full = longint'(ua) - longint'(ub);
      ec   = (ua >= ub);
      r    = sa - sb;
    end else begin
      full = longint'(ua) + longint'(ub) + longint'(ci);
      ec   = ((full >>> w) & 1) != 0;
      r    = sa + sb + longint'(ci);
    end
    es = int'(full & m);
    eo = (r > half - 1) || (r < -half);
  endfunction

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb,
                     input bit ts, input bit tc, input bit hold,
                     input string nm);
    int es;
    bit ec, eo;
    int bad;
    model(8, int'(ta), int'(tb), ts, tc, es, ec, eo);
    a = ta; b = tb; sub = ts; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (hold) begin
        a = 8'($urandom); b = 8'($urandom);
        sub = 1'($urandom); cin = 1'($urandom);
      end
      @(negedge clk);
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s busy_window: bad_cycles=%0d exp=0", nm, bad);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_pulse: done=%b busy=%b exp done=1 busy=0",
               nm, done, busy);
    end
    n_chk++;
    if (sum !== 8'(es) || carry !== ec || ovf !== eo) begin
      n_fail++;
      $display("FAIL %s result: sum=%h c=%b v=%b exp sum=%h c=%b v=%b",
               nm, sum, carry, ovf, 8'(es), ec, eo);
    end
    if (hold) begin
      a = 8'($urandom); b = 8'($urandom);
    end
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done_end: done=%b busy=%b exp 0 0",
               nm, done, busy);
    end
  endtask

  task automatic op1(input bit ta, input bit tb, input bit ts,
                     input bit tc, input string nm);
    int es;
    bit ec, eo;
    model(1, int'(ta), int'(tb), ts, tc, es, ec, eo);
    a1 = ta; b1 = tb; s1_sub = ts; s1_cin = tc; s1_start = 1'b1;
    @(posedge clk); #1;
    s1_start = 1'b0;
    @(negedge clk);
    n_chk++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s w1_busy: busy=%b done=%b exp 1 0",
               nm, busy1, done1);
    end
    @(negedge clk);
    n_chk++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 1'(es) ||
        carry1 !== ec || ovf1 !== eo) begin
      n_fail++;
      $display("FAIL %s w1_result: d=%b s=%b c=%b v=%b exp d=1 s=%b c=%b v=%b",
               nm, done1, sum1, carry1, ovf1, 1'(es), ec, eo);
    end
    @(negedge clk);
    n_chk++;
    if (done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s w1_done_end: done=%b exp 0", nm, done1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 0; sub = 0; cin = 0; a = '0; b = '0;
    s1_start = 0; s1_sub = 0; s1_cin = 0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, sum, carry, ovf} !== 12'h0 ||
        {busy1, done1, sum1, carry1, ovf1} !== 5'h0) begin
      n_fail++;
      $display("FAIL reset_state: w8=%h w1=%h exp 0",
               {busy, done, sum, carry, ovf},
               {busy1, done1, sum1, carry1, ovf1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    op8(8'h0F, 8'h01, 0, 0, 0, "add_0f_01");
    op8(8'hFF, 8'h01, 0, 0, 0, "add_ff_01");
    op8(8'h7F, 8'h01, 0, 0, 0, "add_7f_01");
    op8(8'h80, 8'h80, 0, 0, 0, "add_80_80");
    op8(8'h0F, 8'hF0, 0, 1, 0, "add_cin");
  endtask

  task automatic test_sub();
    op8(8'h05, 8'h07, 1, 0, 0, "sub_05_07");
    op8(8'h80, 8'h01, 1, 0, 0, "sub_80_01");
    op8(8'h05, 8'h07, 1, 1, 0, "sub_05_07_cin");
    op8(8'h80, 8'h01, 1, 1, 0, "sub_80_01_cin");
    op8(8'h33, 8'h33, 1, 0, 0, "sub_equal");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom), 0, "random");
    end
  endtask

  task automatic test_back_to_back();
    op8(8'h21, 8'h42, 0, 0, 1, "hold_first");
    op8(8'h90, 8'h0C, 1, 0, 0, "hold_second");
  endtask

  task automatic test_reset_mid();
    op8(8'hC0, 8'h80, 0, 0, 0, "pre_abort");
    a = 8'hFF; b = 8'h01; sub = 0; cin = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({busy, done, sum, carry, ovf} !== 12'h0) begin
      n_fail++;
      $display("FAIL abort_async: outs=%h exp 0",
               {busy, done, sum, carry, ovf});
    end
    repeat (2) @(negedge clk);
    n_chk++;
    if ({busy, done, sum, carry, ovf} !== 12'h0) begin
      n_fail++;
      $display("FAIL abort_held: outs=%h exp 0",
               {busy, done, sum, carry, ovf});
    end
    rst_n = 1'b1;
    @(negedge clk);
    op8(8'h03, 8'h04, 0, 0, 0, "after_abort");
  endtask

  task automatic test_width1();
    for (int i = 0; i < 4; i++) begin
      op1(1'(i >> 1), 1'(i), 0, 0, "w1_half");
    end
    for (int i = 0; i < 4; i++) begin
      op1(1'(i >> 1), 1'(i), 0, 1, "w1_cin");
      op1(1'(i >> 1), 1'(i), 1, 1'(i), "w1_sub");
    end
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_sub();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder/subtractor, the sequential successor to the combinational half adder cell. It accepts two WIDTH-bit operands on a start strobe and processes one bit per clock, LSB first, through a single full-add stage built from two half-add steps plus a carry flip-flop. It presents sum, carry-out and signed overflow with a one-cycle done pulse. It sits in the datapath library wherever area matters more than latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low; clears all state.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  mode; 0 = A+B+cin, 1 = A-B (two's complement); sampled with start.
- cin  input  1  carry-in; used only when sub=0.
- A  input  WIDTH  operand A; sampled with start.
- B  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; holds its value until the next done.
- carry  output  1  carry-out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  signed overflow: carry into the MSB XOR carry out of the MSB.

## Operation
- FSM states: IDLE, ADD, DONE. Reset state is IDLE.
- IDLE, start=1:
  - Load opA←A.
  - Load opB←(sub ? ~B : B).
  - Set carry register c←(sub ? 1 : cin).
  - Clear bit counter and shift-result register.
  - Go to ADD.
- IDLE, start=0: remain in IDLE.
- ADD, every cycle:
  - Compute s = opA[0]^opB[0]^c.
  - Compute c_next = (opA[0]&opB[0]) | (c&(opA[0]^opB[0])).
  - Shift s into the result MSB, with the result shifting right.
  - Shift opA and opB right by one.
  - c←c_next.
  - Increment the counter.
- On the cycle that processes bit WIDTH-1:
  - Capture c (pre-update) as the MSB carry-in.
  - Go to DONE.
  - Update the sum, carry and overflow outputs.
- DONE: lasts one cycle, then returns to IDLE unconditionally.
- start is ignored in ADD and in DONE. No queuing.
- A, B, sub and cin may change freely after start is sampled; internal copies are used.
- The bit counter is $clog2(WIDTH)+1 bits wide and never wraps within an operation.
- WIDTH=1: exactly one ADD cycle. With sub=0 and cin=0, the block behaves as a registered half adder.
- Reset:
  - Values after reset: busy=0, done=0, sum=0, carry=0, overflow=0. Internal registers are 0.
  - Reset asserted mid-operation aborts immediately. No partial result reaches the outputs.
  - The first start after reset release is honoured normally.

## Timing
- Start sampled at rising edge k (state IDLE):
  - busy=1 from after edge k until edge k+WIDTH.
  - At edge k+WIDTH: sum, carry and overflow update; done=1; busy=0.
  - At edge k+WIDTH+1: done=0; state is IDLE.
- Back-to-back throughput: the next start can be sampled at edge k+WIDTH+2 at the earliest. The minimum period is WIDTH+2 cycles.
- Outputs are registered. There is no combinational path from inputs to outputs.
- done and busy are never high in the same cycle.

## Test plan
- WIDTH=8, A=0x0F, B=0x01, sub=0, cin=0, start at edge k:
  - done high only in cycle k+8..k+9.
  - sum=0x10, carry=0, overflow=0.
  - busy high for 8 cycles.
- WIDTH=8, unsigned wrap and signed overflow:
  - A=0xFF, B=0x01 → sum=0x00, carry=1, overflow=0.
  - A=0x7F, B=0x01 → sum=0x80, carry=0, overflow=1.
  - A=0x80, B=0x80 → sum=0x00, carry=1, overflow=1.
- WIDTH=8, subtract:
  - A=0x05, B=0x07, sub=1 → sum=0xFE, carry=0, overflow=0.
  - A=0x80, B=0x01, sub=1 → sum=0x7F, carry=1, overflow=1.
  - cin=1 during these subtractions has no effect on the result.
- WIDTH=8, start pulsed every cycle during an operation, with A/B changed after sampling:
  - Only the first request executes, using the originally sampled operands.
  - The next start is honoured only once the FSM is back in IDLE.
- WIDTH=8, rst_n pulled low after 4 ADD cycles of 0xFF+0x01:
  - All outputs are 0 asynchronously.
  - After release, a new 0x03+0x04 gives sum=0x07 with done exactly 8 edges after its start.
- WIDTH=1, exhaustive over A, B ∈ {0,1} with cin=0 and sub=0:
  - sum = A^B, carry = A&B.
  - done arrives 1 edge after start.
